// File: rtl/sram_like_pkg.sv
// sram_like_pkg: shared SRAM-like bus size codes and response-entry geometry.
package sram_like_pkg;
    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;
    localparam int RESP_DATA_W  = 32;
    localparam int RESP_CNT_W   = 4;
    localparam int RESP_ENTRY_W = RESP_DATA_W + RESP_CNT_W;
endpackage

// File: rtl/sram_like_resp_fifo.sv
// sram_like_resp_fifo: in-order response queue; each entry counts down to ready and the head self-pops.
module sram_like_resp_fifo
    import sram_like_pkg::*;
#(
    parameter int QDEPTH = 4,
    parameter int DW     = RESP_DATA_W,
    parameter int CW     = RESP_CNT_W
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push_i,
    input  logic [DW-1:0] push_data_i,
    input  logic [CW-1:0] push_cnt_i,
    output logic          full_o,
    output logic          ready_o,
    output logic [DW-1:0] head_data_o
);
    localparam int PW = $clog2(QDEPTH);

    logic [DW-1:0] data_q [QDEPTH];
    logic [CW-1:0] cnt_q  [QDEPTH];
    logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [PW:0]   count_q, count_d;
    logic          pop;

    assign full_o      = count_q == (PW+1)'(QDEPTH);
    assign pop         = (count_q != '0) && (cnt_q[rptr_q] == '0);
    assign ready_o     = pop;
    assign head_data_o = data_q[rptr_q];

    always_comb begin
        wptr_d  = wptr_q + PW'(push_i);
        rptr_d  = rptr_q + PW'(pop);
        count_d = count_q + (PW+1)'(push_i) - (PW+1)'(pop);
    end

    // Slots outside the live window may keep counting; they are rewritten on push.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                data_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            for (int i = 0; i < QDEPTH; i++) begin
                if (push_i && wptr_q == PW'(i)) begin
                    data_q[i] <= push_data_i;
                    cnt_q[i]  <= push_cnt_i;
                end else if (cnt_q[i] != '0) begin
                    cnt_q[i] <= cnt_q[i] - 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/sram_like_responder.sv
// sram_like_responder: SRAM-like slave with word memory, fixed latency and bounded in-order responses.
module sram_like_responder
    import sram_like_pkg::*;
#(
    parameter int MEM_WORDS = 4096,
    parameter int LATENCY   = 2,
    parameter int QDEPTH    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [3:0]  wstrb,
    input  logic [31:0] wdata,
    input  logic        addr_stall,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata
);
    localparam int AW = $clog2(MEM_WORDS);

    logic [31:0]   mem_q [MEM_WORDS];
    logic [AW-1:0] widx;
    logic          full, accept;
    logic [31:0]   push_data;
    logic          unused_bits;

    // Size is informational and byte-lane bits never select a word.
    assign unused_bits = ^{size, addr[1:0], addr[31:AW+2]};

    assign widx      = addr[AW+1:2];
    assign addr_ok   = req & ~addr_stall & ~full & ~reset;
    assign accept    = req & addr_ok;
    assign push_data = wr ? '0 : mem_q[widx];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (accept && wr && wstrb[i])
                mem_q[widx][8*i +: 8] <= wdata[8*i +: 8];
    end

    sram_like_resp_fifo #(
        .QDEPTH(QDEPTH),
        .DW    (RESP_DATA_W),
        .CW    (RESP_CNT_W)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push_i     (accept),
        .push_data_i(push_data),
        .push_cnt_i (RESP_CNT_W'(LATENCY - 1)),
        .full_o     (full),
        .ready_o    (data_ok),
        .head_data_o(rdata)
    );
endmodule

// File: tb/tb_sram_like_responder.sv
// tb_sram_like_responder: directed checks on a LATENCY=2 and a LATENCY=8 responder sharing one stimulus bus.
module tb_sram_like_responder;
    import sram_like_pkg::*;

    logic        clk = 1'b0;
    logic        reset, req, wr, addr_stall;
    logic [1:0]  size;
    logic [31:0] addr, wdata;
    logic [3:0]  wstrb;
    logic        addr_ok_a, data_ok_a, addr_ok_b, data_ok_b;
    logic [31:0] rdata_a, rdata_b;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    sram_like_responder u_a (
        .clk(clk), .reset(reset), .req(req), .wr(wr), .size(size), .addr(addr),
        .wstrb(wstrb), .wdata(wdata), .addr_stall(addr_stall),
        .addr_ok(addr_ok_a), .data_ok(data_ok_a), .rdata(rdata_a)
    );

    sram_like_responder #(.LATENCY(8)) u_b (
        .clk(clk), .reset(reset), .req(req), .wr(wr), .size(size), .addr(addr),
        .wstrb(wstrb), .wdata(wdata), .addr_stall(addr_stall),
        .addr_ok(addr_ok_b), .data_ok(data_ok_b), .rdata(rdata_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_write(input string tag, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        req = 1'b1; wr = 1'b1; addr = a; wdata = d; wstrb = s;
        #1 chk({tag, "_aok"}, addr_ok_a, 1);
        step();
        req = 1'b0; wr = 1'b0;
        #1 chk({tag, "_dok_early"}, data_ok_a, 0);
        step();
        #1 chk({tag, "_dok"}, data_ok_a, 1);
        chk({tag, "_rdata"}, rdata_a, 0);
        step();
    endtask

    task automatic do_read(input string tag, input logic [31:0] a, input logic [31:0] exp);
        req = 1'b1; wr = 1'b0; addr = a;
        #1 chk({tag, "_aok"}, addr_ok_a, 1);
        step();
        req = 1'b0;
        #1 chk({tag, "_dok_early"}, data_ok_a, 0);
        step();
        #1 chk({tag, "_dok"}, data_ok_a, 1);
        chk({tag, "_rdata"}, rdata_a, exp);
        step();
    endtask

    initial begin
        reset = 1'b1; req = 1'b1; wr = 1'b0; addr_stall = 1'b0;
        size = SIZE_WORD; addr = '0; wdata = '0; wstrb = '0;
        #2;
        chk("rst_aok", addr_ok_a, 0);
        chk("rst_dok", data_ok_a, 0);
        chk("rst_rdata", rdata_a, 0);
        @(negedge clk);
        reset = 1'b0; req = 1'b0;
        step();

        do_write("wr_word", 32'h1C, 32'h1234_5678, 4'hF);
        do_read("rd_word", 32'h1C, 32'h1234_5678);
        size = SIZE_BYTE;
        do_write("wr_byte", 32'h1C, 32'h00AB_0000, 4'h4);
        size = SIZE_WORD;
        do_read("rd_byte", 32'h1C, 32'h12AB_5678);

        // Read, write, read back-to-back to the same word.
        req = 1'b1; wr = 1'b0; addr = 32'h1C;
        #1 chk("ord_aok0", addr_ok_a, 1);
        step();
        wr = 1'b1; wdata = 32'hFFFF_FFFF; wstrb = 4'hF;
        #1 chk("ord_aok1", addr_ok_a, 1);
        chk("ord_dok_early", data_ok_a, 0);
        step();
        wr = 1'b0;
        #1 chk("ord_aok2", addr_ok_a, 1);
        chk("ord_dok0", data_ok_a, 1);
        chk("ord_rdata0", rdata_a, 32'h12AB_5678);
        step();
        req = 1'b0;
        #1 chk("ord_dok1", data_ok_a, 1);
        chk("ord_rdata1", rdata_a, 0);
        step();
        #1 chk("ord_dok2", data_ok_a, 1);
        chk("ord_rdata2", rdata_a, 32'hFFFF_FFFF);
        step();
        #1 chk("ord_dok_after", data_ok_a, 0);

        req = 1'b1; wr = 1'b1; wdata = 32'hDEAD_BEEF; addr_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1 chk("stall_aok", addr_ok_a, 0);
            chk("stall_dok", data_ok_a, 0);
            step();
        end
        req = 1'b0; wr = 1'b0; addr_stall = 1'b0;
        step();
        req = 1'b1; addr_stall = 1'b1;
        #1 chk("stall_rd_aok", addr_ok_a, 0);
        addr_stall = 1'b0;
        #1 chk("release_aok", addr_ok_a, 1);
        step();
        req = 1'b0;
        step();
        #1 chk("stall_rd_dok", data_ok_a, 1);
        chk("stall_rd_rdata", rdata_a, 32'hFFFF_FFFF);
        step();

        // LATENCY=8 instance: queue fills after four accepts.
        reset = 1'b1;
        #1 reset = 1'b0;
        req = 1'b1; wr = 1'b0; addr = 32'h40;
        for (int k = 0; k < 10; k++) begin
            #1 chk($sformatf("fq_aok%0d", k), addr_ok_b, (k < 4) || (k == 9));
            chk($sformatf("fq_dok%0d", k), data_ok_b, k >= 8);
            step();
        end
        req = 1'b0;
        reset = 1'b1;
        #1 reset = 1'b0;

        req = 1'b1;
        repeat (4) step();
        req = 1'b0;
        repeat (4) step();
        #1 chk("mid_dok_pre", data_ok_b, 1);
        req = 1'b1; reset = 1'b1;
        #1 chk("mid_dok_rst", data_ok_b, 0);
        chk("mid_aok_rst", addr_ok_b, 0);
        chk("mid_aok_rst_a", addr_ok_a, 0);
        chk("mid_rdata_rst", rdata_b, 0);
        reset = 1'b0;
        #1 chk("mid_aok_post", addr_ok_b, 1);
        step();
        req = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            #1 chk($sformatf("mid_dok%0d", k), data_ok_b, k == 8);
            step();
        end
        #1 chk("mid_dok_after", data_ok_b, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
